reg_bank: RTL
=============

Name: reg_bank

Overview:
- Clocked register set that consumes the routed bus-write path: a 4-bit register select plus 16-bit data commit into one of the architectural registers AR, DR, R1, R2, R3, RA, RB, RC, AC and IR.
- Also handles per-register increment and clear micro-ops, and drives one registered read port back onto the bus.
- Sits between the control unit/datapath bus and the ALU/memory interface.

Parameters:
- DW, 16, data width of every register and of the bus.
- SW, 4, select width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_req  input  1  write request, sampled each rising edge.
- wr_sel  input  SW  write target select.
- wr_data  input  DW  write data.
- wr_ack  output  1  one-cycle acknowledge of a sampled wr_req.
- sel_err  output  1  one-cycle pulse: wr_req with invalid wr_sel.
- inc_en  input  1  increment request.
- inc_sel  input  SW  increment target.
- clr_en  input  1  clear request.
- clr_sel  input  SW  clear target.
- rd_sel  input  SW  read select.
- rd_data  output  DW  registered read data.
- AR, DR, R1, R2, R3, RA, RB, RC, AC, IR  output  DW each  register contents, continuously visible.
- ac_zero  output  1  high when AC == 0 (combinational from AC).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Select encoding:
  - 0000 AR, 0001 DR, 0010 R1, 0011 R2, 0100 R3, 0101 RA, 0110 RB, 0111 RC, 1000 AC, 1010 IR.
  - 1001 is reserved (see Optional Feature).
  - 1011–1111 are invalid.
- Reset: rst high at an edge sets all registers, rd_data, wr_ack and sel_err to 0, so ac_zero = 1.
  - rst overrides every concurrent request. A request sampled on the reset edge is dropped and gets no ack.
- Write:
  - wr_req = 1 at edge N loads wr_data into the selected register at edge N.
  - wr_ack = 1 for the cycle after edge N, then drops unless wr_req is held.
  - Back-to-back requests are accepted every cycle; wr_ack stays high continuously.
- Invalid select:
  - wr_req with reserved or invalid wr_sel: no register changes, wr_ack still pulses, sel_err pulses in the same cycle as wr_ack.
  - inc/clr with an invalid select are silently ignored.
- Increment: inc_en adds 1 to the target modulo 2^DW; FFFF wraps to 0000, no carry output.
- Clear: clr_en sets the target to 0.
- Same-target conflicts in one edge: clr > wr > inc. Only the highest-priority op applies.
- Different targets: wr, inc and clr all apply in the same edge.
- Read:
  - rd_data is registered with 1-cycle latency. At edge N it captures the pre-update value of the register at rd_sel.
  - A read and a write to the same register at edge N return the old value; the new value appears from edge N+1.
  - Invalid rd_sel yields 0.
- ac_zero tracks AC combinationally after each update.

Optional Feature:
- Macro: REG_BANK_PC_EN.
- When defined:
  - Adds output port PC (DW) at select 1001.
  - PC supports write, increment, clear and read under the same rules as the other registers.
  - PC resets to 0.
  - 1001 is no longer an error.
- When undefined:
  - No PC port or storage.
  - 1001 behaves as invalid: sel_err pulse on write, 0 on read.

Test Plan:
- Reset, then write 0x1234 to R2 (0011) -> R2 = 0x1234 after edge; wr_ack high exactly the next cycle; all other registers 0; ac_zero = 1.
- Write 0x00FF to AC with rd_sel = AC at the same edge -> rd_data = 0x0000 that cycle, 0x00FF the next; ac_zero falls to 0.
- Set DR = 0xFFFF, then inc_en on DR -> DR = 0x0000; a second inc gives 0x0001.
- Same edge: clr_en, wr_req (0xAAAA) and inc_en all targeting RB (0110) -> RB = 0x0000. Repeat without clr -> RB = 0xAAAA.
- wr_req with wr_sel = 1100 -> sel_err and wr_ack pulse together; no register changes. With macro off, 1001 gives the same result; with macro on, PC = data.
- Writes issued every cycle, with rst asserted mid-burst -> all registers 0 on the reset edge, wr_ack low the following cycle, and writes resume normally after rst is released.

Source files
------------

// File: rtl/reg_bank_if.sv
// Bus-side signal bundle for reg_bank: write/increment/clear requests, acknowledge, error and
// registered read port. The master drives requests; the slave (reg_bank) answers.
interface reg_bank_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned SW = 4
);
   logic          wr_req;
   logic [SW-1:0] wr_sel;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          sel_err;
   logic          inc_en;
   logic [SW-1:0] inc_sel;
   logic          clr_en;
   logic [SW-1:0] clr_sel;
   logic [SW-1:0] rd_sel;
   logic [DW-1:0] rd_data;

   modport master (
      output wr_req, wr_sel, wr_data, inc_en, inc_sel, clr_en, clr_sel, rd_sel,
      input  wr_ack, sel_err, rd_data
   );

   modport slave (
      input  wr_req, wr_sel, wr_data, inc_en, inc_sel, clr_en, clr_sel, rd_sel,
      output wr_ack, sel_err, rd_data
   );
endinterface

// File: rtl/reg_bank.sv
// Architectural register set with write/increment/clear micro-ops and one registered read port.
// Define REG_BANK_PC_EN to add the PC register at select 1001.
module reg_bank #(
   parameter int unsigned DW = 16,
   parameter int unsigned SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   reg_bank_if.slave     bus,
   output logic [DW-1:0] AR,
   output logic [DW-1:0] DR,
   output logic [DW-1:0] R1,
   output logic [DW-1:0] R2,
   output logic [DW-1:0] R3,
   output logic [DW-1:0] RA,
   output logic [DW-1:0] RB,
   output logic [DW-1:0] RC,
   output logic [DW-1:0] AC,
   output logic [DW-1:0] IR,
`ifdef REG_BANK_PC_EN
   output logic [DW-1:0] PC,
`endif
   output logic          ac_zero
);

   localparam int unsigned NumRegs = 11;
   localparam int unsigned IdxAc   = 8;
   localparam int unsigned IdxPc   = 9;
`ifdef REG_BANK_PC_EN
   localparam bit PcEn = 1'b1;
`else
   localparam bit PcEn = 1'b0;
`endif

   function automatic logic sel_valid(input logic [SW-1:0] sel);
      return (sel <= SW'(NumRegs - 1)) && ((sel != SW'(IdxPc)) || PcEn);
   endfunction

   logic [DW-1:0] regs_q [NumRegs];
   logic [DW-1:0] regs_d [NumRegs];
   logic [DW-1:0] rd_q, rd_d;
   logic          wr_ack_q, sel_err_q;

   // Per-register priority: clear beats write beats increment.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NumRegs; i++) begin
         regs_d[i] = '0;
         if (sel_valid(SW'(i))) begin
            regs_d[i] = regs_q[i];
            if (bus.rd_sel == SW'(i)) begin
               rd_d = regs_q[i];
            end
            if (bus.clr_en && (bus.clr_sel == SW'(i))) begin
               regs_d[i] = '0;
            end else if (bus.wr_req && (bus.wr_sel == SW'(i))) begin
               regs_d[i] = bus.wr_data;
            end else if (bus.inc_en && (bus.inc_sel == SW'(i))) begin
               regs_d[i] = regs_q[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         rd_q      <= '0;
         wr_ack_q  <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= regs_d[i];
         end
         rd_q      <= rd_d;
         wr_ack_q  <= bus.wr_req;
         sel_err_q <= bus.wr_req && !sel_valid(bus.wr_sel);
      end
   end

   assign bus.wr_ack  = wr_ack_q;
   assign bus.sel_err = sel_err_q;
   assign bus.rd_data = rd_q;

   assign AR = regs_q[0];
   assign DR = regs_q[1];
   assign R1 = regs_q[2];
   assign R2 = regs_q[3];
   assign R3 = regs_q[4];
   assign RA = regs_q[5];
   assign RB = regs_q[6];
   assign RC = regs_q[7];
   assign AC = regs_q[IdxAc];
   assign IR = regs_q[10];
`ifdef REG_BANK_PC_EN
   assign PC = regs_q[IdxPc];
`endif

   assign ac_zero = (regs_q[IdxAc] == '0);

endmodule
